pc_fetch: RTL and testbench
===========================

// Module: pc_fetch
// PURPOSE
//  Consumer end of the next-PC interface. Holds the architectural PC and drives the
//  instruction-memory request for it. Returns pc_plus (PC+4) to the next-PC logic and
//  accepts its nextPC result only when the core signals the current instruction is retired.
//  Sits between the next-PC computation and the instruction memory.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset (word aligned)
//  TIMEOUT    16             max cycles imem_req may wait for imem_ready before bus_err
// PORTS
//  clock        in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  next_pc      in   32  PC chosen by the next-PC logic for the following instruction
//  advance      in   1   core retires current instruction; load next_pc this edge
//  imem_req     out  1   instruction fetch request, held until imem_ready
//  imem_addr    out  32  fetch address (= pc while imem_req)
//  imem_ready   in   1   memory returns imem_rdata this cycle
//  imem_rdata   in   32  fetched instruction word
//  instr        out  32  latched instruction for decode
//  instr_valid  out  1   instr holds the word for the current pc
//  pc           out  32  current PC
//  pc_plus      out  32  pc + 4, combinational, to the next-PC logic
//  misaligned   out  1   sticky: next_pc[1:0] != 0 was presented on advance
//  bus_err      out  1   sticky: fetch timed out
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0,
//   misaligned=0, bus_err=0, timeout count=0. Any in-flight fetch is abandoned.
//  States:
//   IDLE  -> FETCH next edge, unconditionally.
//   FETCH: imem_req=1, imem_addr=pc, count++ each cycle.
//     imem_ready=1 -> instr<=imem_rdata, instr_valid<=1, count<=0, go HOLD
//       (single-cycle fetch: one cycle in FETCH, instr_valid high the next cycle).
//     count reaches TIMEOUT-1 with no ready -> bus_err<=1, go HALT.
//     advance is ignored in FETCH.
//   HOLD:  imem_req=0, instr_valid=1.
//     advance=1 and next_pc[1:0]==0 -> pc<=next_pc, instr_valid<=0, go FETCH.
//     advance=1 and next_pc[1:0]!=0 -> misaligned<=1, pc unchanged, go HALT.
//   HALT:  imem_req=0, instr_valid=0. Exit only via reset.
//  Ready and timeout in the same cycle: ready wins, no bus_err.
//  pc_plus = pc + 32'd4 mod 2^32. 32'hFFFF_FFFC gives 0.
//  next_pc == pc (branch to self) is legal: the same address is refetched.
//  imem_ready outside FETCH is ignored. instr only changes on a FETCH capture.
// STRUCTURE
//  Shared package/header (mips_defs):
//   - state encoding localparams ST_IDLE, ST_FETCH, ST_HOLD, ST_HALT
//   - PC_STEP = 32'd4
//  One sub-module, fetch_timer: counter with clear/enable/expire, width $clog2(TIMEOUT).
//  Rest is a single always block for the FSM and registers, plus continuous assigns.
// TESTING
//  1. Reset, ready one cycle after req -> imem_addr=0, instr=imem_rdata, pc_plus=4.
//  2. HOLD, next_pc=32'h40, advance -> next cycle imem_req=1, imem_addr=32'h40.
//  3. advance with next_pc=32'h42 -> misaligned=1, pc stays, imem_req stays 0.
//  4. TIMEOUT=16, ready never asserted -> bus_err=1 after 16 req cycles, then HALT.
//  5. Ready on cycle 16 together with expiry -> instr captured, bus_err=0.
//  6. reset asserted mid-FETCH -> imem_req=0 immediately, pc=RESET_PC, flags clear.
//  7. pc=32'hFFFF_FFFC -> pc_plus=0. advance during FETCH -> pc unchanged.

Source files
------------

// File: rtl/mips_defs.sv
// Shared definitions for the fetch front end: FSM state encoding and PC arithmetic.
package mips_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Counter width for a timeout budget; never narrower than one bit.
    function automatic int timer_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// Cycle counter for one outstanding fetch: clear wins over enable, expire flags the last allowed cycle.
module fetch_timer
    import mips_defs::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = timer_width(TIMEOUT);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == LIMIT);

endmodule

// File: rtl/pc_fetch.sv
// Holds the architectural PC, fetches the instruction at it, and loads next_pc when the core retires.
module pc_fetch
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus,
    output logic        misaligned,
    output logic        bus_err,
    output state_t      fsm_state
);

    state_t state;
    logic   expire;

    // Memory handshake: imem_req stays high every FETCH cycle until the first cycle
    // imem_ready is high; that cycle completes the transfer and imem_rdata is captured.
    fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  ((state != ST_FETCH) || imem_ready),
        .enable (state == ST_FETCH),
        .expire (expire)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            misaligned  <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_FETCH;
                end
                ST_FETCH: begin
                    // Ready takes priority over an expiry landing in the same cycle.
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= ST_HOLD;
                    end else if (expire) begin
                        bus_err <= 1'b1;
                        state   <= ST_HALT;
                    end
                end
                ST_HOLD: begin
                    if (advance) begin
                        instr_valid <= 1'b0;
                        if (next_pc[1:0] == 2'b00) begin
                            pc    <= next_pc;
                            state <= ST_FETCH;
                        end else begin
                            misaligned <= 1'b1;
                            state      <= ST_HALT;
                        end
                    end
                end
                default: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = pc;
    assign pc_plus   = pc + PC_STEP;
    assign fsm_state = state;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: a vector table for the main fetch/advance flow plus timeout and reset sequences.
module tb_pc_fetch;
    import mips_defs::*;

    logic        clock;
    logic        reset;
    logic [31:0] next_pc;
    logic        advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        misaligned;
    logic        bus_err;
    state_t      fsm_state;

    int tests;
    int failed;

    pc_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .next_pc     (next_pc),
        .advance     (advance),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus     (pc_plus),
        .misaligned  (misaligned),
        .bus_err     (bus_err),
        .fsm_state   (fsm_state)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        adv;
        logic [31:0] npc;
        logic        rdy;
        logic [31:0] rdata;
        logic [1:0]  e_state;
        logic        e_req;
        logic [31:0] e_pc;
        logic [31:0] e_pc_plus;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_mis;
        logic        e_berr;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic req,
                             input logic [31:0] p, input logic [31:0] pp, input logic [31:0] ins,
                             input logic vld, input logic mis, input logic berr);
        check({tag, ".state"}, 32'(fsm_state), 32'(st));
        check({tag, ".imem_req"}, 32'(imem_req), 32'(req));
        check({tag, ".pc"}, pc, p);
        check({tag, ".pc_plus"}, pc_plus, pp);
        check({tag, ".instr"}, instr, ins);
        check({tag, ".instr_valid"}, 32'(instr_valid), 32'(vld));
        check({tag, ".misaligned"}, 32'(misaligned), 32'(mis));
        check({tag, ".bus_err"}, 32'(bus_err), 32'(berr));
        if (req) check({tag, ".imem_addr"}, imem_addr, p);
    endtask

    // Driver tasks: inputs change #1 after a rising edge, outputs sampled there too.
    task automatic drive(input logic adv, input logic [31:0] npc, input logic rdy, input logic [31:0] rd);
        advance    = adv;
        next_pc    = npc;
        imem_ready = rdy;
        imem_rdata = rd;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        reset  = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0);

        //            adv   npc            rdy   rdata          state     req   pc             pc_plus        instr          vld   mis   berr
        vecs[0]  = '{1'b0, 32'h0,         1'b0, 32'h0,         ST_FETCH, 1'b1, 32'h0,         32'h4,         32'h0,         1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0,         1'b1, 32'hAABB_CCDD, ST_HOLD,  1'b0, 32'h0,         32'h4,         32'hAABB_CCDD, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,         1'b1, 32'h1111_1111, ST_HOLD,  1'b0, 32'h0,         32'h4,         32'hAABB_CCDD, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 32'h40,        1'b0, 32'h0,         ST_FETCH, 1'b1, 32'h40,        32'h44,        32'hAABB_CCDD, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 32'h80,        1'b0, 32'h0,         ST_FETCH, 1'b1, 32'h40,        32'h44,        32'hAABB_CCDD, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,         1'b1, 32'h1234_5678, ST_HOLD,  1'b0, 32'h40,        32'h44,        32'h1234_5678, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 32'h40,        1'b0, 32'h0,         ST_FETCH, 1'b1, 32'h40,        32'h44,        32'h1234_5678, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,         1'b1, 32'hCAFE_F00D, ST_HOLD,  1'b0, 32'h40,        32'h44,        32'hCAFE_F00D, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         ST_FETCH, 1'b1, 32'hFFFF_FFFC, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,         1'b1, 32'h0BAD_BEEF, ST_HOLD,  1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0BAD_BEEF, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 32'h42,        1'b0, 32'h0,         ST_HALT,  1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0BAD_BEEF, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 32'h0,         1'b1, 32'h5555_5555, ST_HALT,  1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0BAD_BEEF, 1'b0, 1'b1, 1'b0};

        #2;
        check_all("reset", ST_IDLE, 1'b0, 32'h0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        check_all("reset_held", ST_IDLE, 1'b0, 32'h0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0);

        // Main flow: one table row per clock.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].adv, vecs[i].npc, vecs[i].rdy, vecs[i].rdata);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_req, vecs[i].e_pc,
                      vecs[i].e_pc_plus, vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_mis, vecs[i].e_berr);
        end

        // Reset out of HALT clears misaligned.
        do_reset();
        check_all("rst_after_mis", ST_IDLE, 1'b0, 32'h0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0);

        // Timeout: 16 request cycles with no ready, then bus_err and HALT.
        step();
        check_all("to_first", ST_FETCH, 1'b1, 32'h0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int c = 2; c <= 16; c++) begin
            step();
            check($sformatf("to_cycle%0d.req", c), 32'(imem_req), 32'h1);
        end
        step();
        check_all("to_expired", ST_HALT, 1'b0, 32'h0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h100, 1'b1, 32'h7777_7777);
        step();
        step();
        check_all("to_halt_sticky", ST_HALT, 1'b0, 32'h0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b1);

        do_reset();
        check_all("rst_after_berr", ST_IDLE, 1'b0, 32'h0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0);

        // Ready arrives in the 16th request cycle, coinciding with expiry: ready wins.
        step();
        for (int c = 2; c <= 16; c++) step();
        check("late_ready.still_fetch", 32'(fsm_state), 32'(ST_FETCH));
        drive(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        step();
        check_all("late_ready", ST_HOLD, 1'b0, 32'h0, 32'h4, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a fetch.
        drive(1'b1, 32'h100, 1'b0, 32'h0);
        step();
        check_all("pre_async", ST_FETCH, 1'b1, 32'h100, 32'h104, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_rst", ST_IDLE, 1'b0, 32'h0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0);
        #3;
        reset = 1'b0;
        step();
        check_all("post_async", ST_FETCH, 1'b1, 32'h0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
